// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: single-outstanding imem requests, registered word toward decode.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirect raises fetch_fault and parks in FAULT.
module inst_fetch_stage #(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_fault
);

    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
`ifdef FETCH_MISALIGN_CHECK_EN
        , S_FAULT
`endif
    } state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic            req_valid;
    logic [XLEN-1:0] redirect_target;

    assign redirect_target = redirect_pc & ~XLEN'(3);
    assign imem_req_valid  = req_valid;
    assign imem_req_addr   = fetch_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault;
    logic misaligned;
    assign misaligned  = |redirect_pc[1:0];
    assign fetch_fault = fault;
`else
    assign fetch_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_REQ;
            fetch_pc  <= RESET_PC;
            req_pc    <= RESET_PC;
            if_pc     <= RESET_PC;
            if_instr  <= NOP;
            req_valid <= 1'b0;
            if_valid  <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            fault     <= 1'b0;
`endif
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        else if (state == S_FAULT) begin
            req_valid <= 1'b0;
            if_valid  <= 1'b0;
        end
        else if (redirect_valid && misaligned) begin
            state     <= S_FAULT;
            fault     <= 1'b1;
            req_valid <= 1'b0;
            if_valid  <= 1'b0;
        end
`endif
        else if (redirect_valid) begin
            fetch_pc <= redirect_target;
            if_valid <= 1'b0;
            // An accepted-but-unanswered request must have its response swallowed in DRAIN.
            if ((state == S_REQ && req_valid && imem_req_ready) ||
                ((state == S_WAIT || state == S_DRAIN) && !imem_rsp_valid)) begin
                state     <= S_DRAIN;
                req_valid <= 1'b0;
            end else begin
                state     <= S_REQ;
                req_valid <= 1'b1;
            end
        end
        else begin
            case (state)
                S_REQ: begin
                    if (!req_valid) begin
                        req_valid <= 1'b1;
                    end else if (imem_req_ready) begin
                        req_pc    <= fetch_pc;
                        fetch_pc  <= fetch_pc + XLEN'(4);
                        req_valid <= 1'b0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if_instr <= imem_rsp_data;
                        if_pc    <= req_pc;
                        if_valid <= 1'b1;
                        state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (if_ready) begin
                        if_valid  <= 1'b0;
                        req_valid <= 1'b1;
                        state     <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (imem_rsp_valid) begin
                        req_valid <= 1'b1;
                        state     <= S_REQ;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Scoreboard bench for inst_fetch_stage: expected fetch stream queued by stimulus, checked by a monitor.
module tb_inst_fetch_stage;

    localparam logic [31:0] KEY      = 32'hA5A5_0000;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fetch_fault;

    inst_fetch_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_next;
    logic [31:0] exp_req_addr;
    bit          exp_req_chk = 0;
    bit          mem_pend = 0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr;
    int          lat_min = 1, lat_max = 1;
    bit          rdy_rand = 0, fast = 1, stall = 0, thru = 0, have_last = 0;
    int          cyc = 0, last_hs = 0, acc_cnt = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    // Monitor: handshakes and request acceptances seen on the cycle before the edge.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (if_valid && if_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_delivery actual_pc=%h required=none", if_pc);
                end else begin
                    logic [31:0] pc;
                    pc = exp_q.pop_front();
                    check("if_pc", if_pc, pc);
                    check("if_instr", if_instr, pc ^ KEY);
                    if (thru && have_last) check("interval", 32'(cyc - last_hs), 32'd3);
                    have_last = 1;
                    last_hs = cyc;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                acc_cnt++;
                check("req_align", {30'd0, imem_req_addr[1:0]}, 32'd0);
                if (mem_pend) begin
                    checks++;
                    errors++;
                    $display("FAIL single_outstanding actual=2 required=1");
                end
                if (exp_req_chk && !redirect_valid) begin
                    check("req_addr_after_redirect", imem_req_addr, exp_req_addr);
                    exp_req_chk = 0;
                end
                mem_pend = 1;
                mem_addr = imem_req_addr;
                mem_cnt  = $urandom_range(lat_max, lat_min) - 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_pend && mem_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_addr ^ KEY;
            mem_pend       = 0;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom();
            if (mem_pend) mem_cnt--;
        end
        imem_req_ready = rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1;
        if_ready = stall ? 1'b0 :
                   ((exp_q.size() > 0) && (fast || ($urandom_range(3, 0) != 0)));
        redirect_valid = 1'b0;
        redirect_pc    = $urandom();
    endtask

    task automatic redirect(input logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        if_ready       = 1'b0;
        exp_req_addr   = t & 32'hFFFF_FFFC;
        exp_req_chk    = 1;
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
        exp_next = start + 32'(4 * n);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) tick();
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual_left=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int acc_snap;

        // Reset state
        repeat (3) tick();
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_fault", {31'd0, fetch_fault}, 32'd0);
        check("rst_if_pc", if_pc, RESET_PC);
        check("rst_if_instr", if_instr, 32'h0000_0013);
        check("rst_req_addr", imem_req_addr, RESET_PC);

        // Back-to-back fetch with 1-cycle memory: one instruction per 3 cycles
        thru = 1;
        have_last = 0;
        push_seq(RESET_PC, 4);
        rst_n = 1'b1;
        drain(100);
        thru = 0;

        // Decode stall holds the word and blocks new requests
        stall = 1;
        push_seq(exp_next, 2);
        for (int i = 0; i < 50 && !if_valid; i++) tick();
        check("stall_valid", {31'd0, if_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_pc", if_pc, 32'd16);
            check("stall_instr", if_instr, 32'd16 ^ KEY);
            check("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
        end
        stall = 0;
        drain(100);

        // Redirect while WAIT, response 2 cycles later must be drained
        lat_min = 3; lat_max = 3;
        push_seq(exp_next, 1);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (exp_q.size() == 0 && mem_pend && mem_cnt == 1 && !imem_rsp_valid) found = 1;
        end
        check("wait_reached", {31'd0, found}, 32'd1);
        redirect(32'h0000_0100);
        push_seq(32'h0000_0100, 2);
        drain(100);

        // Redirect coinciding with the response in WAIT
        lat_min = 2; lat_max = 2;
        push_seq(exp_next, 1);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (exp_q.size() == 0 && imem_rsp_valid) found = 1;
        end
        check("rsp_reached", {31'd0, found}, 32'd1);
        redirect(32'h0000_0200);
        tick();
        check("rsp_redir_if_valid", {31'd0, if_valid}, 32'd0);
        check("rsp_redir_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("rsp_redir_req_addr", imem_req_addr, 32'h0000_0200);
        push_seq(32'h0000_0200, 2);
        drain(100);

        // PC wraps at the top of the address space
        lat_min = 1; lat_max = 1;
        tick();
        redirect(32'hFFFF_FFFC);
        push_seq(32'hFFFF_FFFC, 2);
        drain(100);

        // Randomized redirects, latencies and backpressure
        fast = 0;
        rdy_rand = 1;
        for (int k = 0; k < 25; k++) begin
            logic [31:0] t;
            lat_max = $urandom_range(4, 1);
            repeat ($urandom_range(6, 0)) tick();
            tick();
            t = $urandom() & 32'hFFFF_FFFC;
            redirect(t);
            push_seq(t, $urandom_range(5, 1));
            drain(400);
        end

        // Misaligned redirect
        lat_max = 1;
        rdy_rand = 0;
        tick();
`ifdef FETCH_MISALIGN_CHECK_EN
        redirect(32'h0000_0102);
        exp_req_chk = 0;
        tick();
        tick();
        check("fault_set", {31'd0, fetch_fault}, 32'd1);
        acc_snap = acc_cnt;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 2) begin
                redirect(32'h0000_0300);
                exp_req_chk = 0;
            end
            check("fault_no_req", {31'd0, imem_req_valid}, 32'd0);
            check("fault_no_valid", {31'd0, if_valid}, 32'd0);
        end
        check("fault_sticky", {31'd0, fetch_fault}, 32'd1);
        check("fault_accepts", 32'(acc_cnt), 32'(acc_snap));
`else
        acc_snap = acc_cnt;
        redirect(32'h0000_0102);
        push_seq(32'h0000_0100, 2);
        drain(100);
        check("fault_tied_low", {31'd0, fetch_fault}, 32'd0);
`endif

        // Reset again mid-flight
        rst_n = 1'b0;
        mem_pend = 0;
        exp_req_chk = 0;
        tick();
        tick();
        check("rst2_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst2_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst2_fault", {31'd0, fetch_fault}, 32'd0);
        check("rst2_if_pc", if_pc, RESET_PC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
